// File: rtl/usb_pkg.sv
// Shared definitions for the USB endpoint data path: buffer depth,
// AHB transfer size encoding and a helper to turn that encoding into a byte count.
package usb_pkg;

  localparam int BUFFER_DEPTH = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } data_size_t;

  // Encoding 3 is not a legal AHB size here and is handled as a full word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] bytes;
    case (size)
      SIZE_BYTE: bytes = 3'd1;
      SIZE_HALF: bytes = 3'd2;
      default:   bytes = 3'd4;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/usb_data_buffer.sv
// Byte-wide circular FIFO sitting between the AHB-Lite slave and the USB
// serial engines. The AHB side moves 1, 2 or 4 bytes per access, the USB side
// one byte. Head data is presented first-word-fall-through on both read ports.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH  = BUFFER_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int OCC_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [31:0]      tx_data,
  input  logic             get_rx_data,
  input  logic [1:0]       data_size,
  output logic [31:0]      rx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             overflow,
  output logic             underflow
);

  // One extra bit of headroom so occupancy plus a full push never wraps.
  localparam int            CW      = OCC_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W-1:0] r_wptr;
  logic [OCC_W-1:0]  r_occ;
  logic [1:0]        r_flags;

  logic [CW-1:0]     w_n;
  logic [CW-1:0]     w_occ;
  logic              w_ahbPushOk;
  logic [CW-1:0]     w_ahbPushCnt;
  logic              w_rxPushOk;
  logic [CW-1:0]     w_pushCnt;
  logic [CW-1:0]     w_ahbAvail;
  logic [CW-1:0]     w_ahbPopCnt;
  logic              w_txPopOk;
  logic [CW-1:0]     w_popCnt;
  logic              w_overflow;
  logic              w_underflow;

  logic              w_wrEn   [5];
  logic [ADDR_W-1:0] w_wrAddr [5];
  logic [7:0]        w_wrData [5];

  // Accept/drop pushes against the registered occupancy (AHB first, receiver
  // second) and clamp pops to what is stored (AHB first, transmitter second).
  always_comb begin
    w_n          = CW'(size_to_bytes(data_size));
    w_occ        = CW'(r_occ);
    w_ahbPushOk  = store_tx_data && ((w_occ + w_n) <= DEPTH_C);
    w_ahbPushCnt = w_ahbPushOk ? w_n : '0;
    w_rxPushOk   = store_rx_packet_data && ((w_occ + w_ahbPushCnt + CW'(1)) <= DEPTH_C);
    w_pushCnt    = w_ahbPushCnt + CW'(w_rxPushOk);
    w_ahbAvail   = (w_n > w_occ) ? w_occ : w_n;
    w_ahbPopCnt  = get_rx_data ? w_ahbAvail : '0;
    w_txPopOk    = get_tx_packet_data && (w_occ > w_ahbPopCnt);
    w_popCnt     = w_ahbPopCnt + CW'(w_txPopOk);
    w_overflow   = (store_tx_data && !w_ahbPushOk) ||
                   (store_rx_packet_data && !w_rxPushOk);
    w_underflow  = (get_rx_data && (w_n > w_occ)) ||
                   (get_tx_packet_data && !w_txPopOk);
  end

  // Four AHB write lanes followed by the receiver byte, placed right after
  // however many AHB bytes were accepted this cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_wrEn[k]   = w_ahbPushOk && (CW'(k) < w_n);
      w_wrAddr[k] = r_wptr + ADDR_W'(k);
      w_wrData[k] = tx_data[8*k +: 8];
    end
    w_wrEn[4]   = w_rxPushOk;
    w_wrAddr[4] = r_wptr + ADDR_W'(w_ahbPushCnt);
    w_wrData[4] = rx_packet_data;
  end

  // AHB read data: little-endian from the head, lanes past the stored bytes read 0.
  always_comb begin
    rx_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (CW'(k) < w_ahbAvail) begin
        rx_data[8*k +: 8] = r_mem[r_rptr + ADDR_W'(k)];
      end
    end
  end

  // Storage array: zeroed on reset, untouched by a flush.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (!clear) begin
      for (int k = 0; k < 5; k++) begin
        if (w_wrEn[k]) begin
          r_mem[w_wrAddr[k]] <= w_wrData[k];
        end
      end
    end
  end

  // Pointers, occupancy and the overflow/underflow pulse register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_occ   <= '0;
      r_flags <= '0;
    end else if (clear) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_occ   <= '0;
      r_flags <= '0;
    end else begin
      r_wptr  <= r_wptr + ADDR_W'(w_pushCnt);
      r_rptr  <= r_rptr + ADDR_W'(w_popCnt);
      r_occ   <= OCC_W'(w_occ + w_pushCnt - w_popCnt);
      r_flags <= {w_overflow, w_underflow};
    end
  end

  assign tx_packet_data   = r_mem[r_rptr];
  assign buffer_occupancy = r_occ;
  assign overflow         = r_flags[1];
  assign underflow        = r_flags[0];

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed scenarios plus a randomized
// run, all compared against a byte-queue reference model.
module tb_usb_data_buffer;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic        store_tx_data;
  logic [31:0] tx_data;
  logic        get_rx_data;
  logic [1:0]  data_size;
  logic [31:0] rx_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic [6:0]  buffer_occupancy;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int fails  = 0;

  byte unsigned mq[$];
  logic        mdlOvf;
  logic        mdlUnf;
  logic [31:0] mdlRxData;
  logic [31:0] sampledRxData;
  logic [7:0]  sampledTxByte;

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .data_size            (data_size),
    .rx_data              (rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .overflow             (overflow),
    .underflow            (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain byte queue with a 64-byte capacity.
  function automatic void modelStep();
    int n, space, avail, take;
    byte unsigned newBytes[$];
    n = (data_size == 2'd0) ? 1 : (data_size == 2'd1) ? 2 : 4;
    mdlRxData = 32'h0;
    for (int k = 0; k < n; k++) begin
      if (k < mq.size()) mdlRxData[8*k +: 8] = mq[k];
    end
    mdlOvf = 1'b0;
    mdlUnf = 1'b0;
    if (clear) begin
      mq.delete();
      return;
    end
    space = 64 - mq.size();
    avail = mq.size();
    if (store_tx_data) begin
      if (n <= space) begin
        for (int k = 0; k < n; k++) newBytes.push_back(tx_data[8*k +: 8]);
        space -= n;
      end else mdlOvf = 1'b1;
    end
    if (store_rx_packet_data) begin
      if (space >= 1) newBytes.push_back(rx_packet_data);
      else mdlOvf = 1'b1;
    end
    if (get_rx_data) begin
      take = n;
      if (n > avail) begin
        mdlUnf = 1'b1;
        take = avail;
      end
      repeat (take) void'(mq.pop_front());
      avail -= take;
    end
    if (get_tx_packet_data) begin
      if (avail > 0) void'(mq.pop_front());
      else mdlUnf = 1'b1;
    end
    foreach (newBytes[i]) mq.push_back(newBytes[i]);
  endfunction

  // Drive one cycle of inputs, capture the combinational outputs before the
  // edge, step the model, then release the strobes just after the edge.
  task automatic applyStimulus(input logic iTxS, input logic [31:0] iTxD, input logic [1:0] iSz,
                               input logic iRxG, input logic iTxG, input logic iRxS,
                               input logic [7:0] iRxD, input logic iClr);
    store_tx_data        = iTxS;
    tx_data              = iTxD;
    data_size            = iSz;
    get_rx_data          = iRxG;
    get_tx_packet_data   = iTxG;
    store_rx_packet_data = iRxS;
    rx_packet_data       = iRxD;
    clear                = iClr;
    #2;
    sampledRxData = rx_data;
    sampledTxByte = tx_packet_data;
    modelStep();
    @(posedge clk);
    #1;
    store_tx_data        = 1'b0;
    get_rx_data          = 1'b0;
    get_tx_packet_data   = 1'b0;
    store_rx_packet_data = 1'b0;
    clear                = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic popTx();
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic writeAhb(input logic [31:0] d, input logic [1:0] sz);
    applyStimulus(1'b1, d, sz, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic readAhb(input logic [1:0] sz);
    applyStimulus(1'b0, 32'h0, sz, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic flush();
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    clear = 1'b0; store_tx_data = 1'b0; tx_data = '0; get_rx_data = 1'b0; data_size = 2'd0;
    get_tx_packet_data = 1'b0; store_rx_packet_data = 1'b0; rx_packet_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (buffer_occupancy !== 7'd0) begin fails++; $display("[TB] FAIL reset_occ: got %0d expected 0", buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_tx: got %h expected 00", tx_packet_data); end
    checks++; if (rx_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_rx: got %h expected 0", rx_data); end
    checks++; if ({overflow, underflow} !== 2'b00) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 00", {overflow, underflow}); end
    n_rst = 1'b1;
    mq.delete();
    pushByte(8'hA5);
    checks++; if (buffer_occupancy !== 7'd1) begin fails++; $display("[TB] FAIL first_push_occ: got %0d expected 1", buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'hA5) begin fails++; $display("[TB] FAIL first_push_tx: got %h expected a5", tx_packet_data); end
  endtask

  task automatic test_word_write();
    logic [7:0] expBytes [4];
    expBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    flush();
    writeAhb(32'h44332211, 2'd2);
    checks++; if (buffer_occupancy !== 7'd4) begin fails++; $display("[TB] FAIL word_occ: got %0d expected 4", buffer_occupancy); end
    for (int i = 0; i < 4; i++) begin
      popTx();
      checks++; if (sampledTxByte !== expBytes[i]) begin fails++; $display("[TB] FAIL word_byte%0d: got %h expected %h", i, sampledTxByte, expBytes[i]); end
      checks++; if (buffer_occupancy !== 7'(3 - i)) begin fails++; $display("[TB] FAIL word_pop_occ%0d: got %0d expected %0d", i, buffer_occupancy, 3 - i); end
    end
  endtask

  task automatic test_overflow();
    flush();
    repeat (15) writeAhb($urandom, 2'd2);
    repeat (3) pushByte(8'($urandom));
    checks++; if (buffer_occupancy !== 7'd63) begin fails++; $display("[TB] FAIL fill_occ: got %0d expected 63", buffer_occupancy); end
    writeAhb(32'hCAFEF00D, 2'd2);
    checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_pulse: got %b expected 1", overflow); end
    checks++; if (buffer_occupancy !== 7'd63) begin fails++; $display("[TB] FAIL ovf_occ: got %0d expected 63", buffer_occupancy); end
    pushByte(8'h5A);
    checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    checks++; if (buffer_occupancy !== 7'd64) begin fails++; $display("[TB] FAIL full_occ: got %0d expected 64", buffer_occupancy); end
    pushByte(8'h77);
    checks++; if ({overflow, buffer_occupancy} !== {1'b1, 7'd64}) begin fails++; $display("[TB] FAIL full_push: got ovf %b occ %0d expected ovf 1 occ 64", overflow, buffer_occupancy); end
  endtask

  task automatic test_underflow();
    flush();
    writeAhb(32'hDEADBBAA, 2'd1);
    checks++; if (buffer_occupancy !== 7'd2) begin fails++; $display("[TB] FAIL unf_setup_occ: got %0d expected 2", buffer_occupancy); end
    readAhb(2'd2);
    checks++; if (sampledRxData !== 32'h0000BBAA) begin fails++; $display("[TB] FAIL unf_rxdata: got %h expected 0000bbaa", sampledRxData); end
    checks++; if ({underflow, buffer_occupancy} !== {1'b1, 7'd0}) begin fails++; $display("[TB] FAIL unf_pulse: got unf %b occ %0d expected unf 1 occ 0", underflow, buffer_occupancy); end
    idle();
    checks++; if (underflow !== 1'b0) begin fails++; $display("[TB] FAIL unf_oneshot: got %b expected 0", underflow); end
    popTx();
    checks++; if ({underflow, buffer_occupancy} !== {1'b1, 7'd0}) begin fails++; $display("[TB] FAIL unf_empty_tx: got unf %b occ %0d expected unf 1 occ 0", underflow, buffer_occupancy); end
  endtask

  task automatic test_wrap();
    flush();
    repeat (15) writeAhb($urandom, 2'd2);
    for (int i = 0; i < 15; i++) begin
      readAhb(2'd2);
      checks++; if (sampledRxData !== mdlRxData) begin fails++; $display("[TB] FAIL wrap_read%0d: got %h expected %h", i, sampledRxData, mdlRxData); end
    end
    writeAhb(32'h03020100, 2'd2);
    writeAhb(32'h07060504, 2'd2);
    checks++; if (buffer_occupancy !== 7'd8) begin fails++; $display("[TB] FAIL wrap_occ: got %0d expected 8", buffer_occupancy); end
    for (int i = 0; i < 8; i++) begin
      popTx();
      checks++; if (sampledTxByte !== 8'(i)) begin fails++; $display("[TB] FAIL wrap_byte%0d: got %h expected %h", i, sampledTxByte, 8'(i)); end
    end
    checks++; if (buffer_occupancy !== 7'd0) begin fails++; $display("[TB] FAIL wrap_empty: got %0d expected 0", buffer_occupancy); end
  endtask

  task automatic test_back_to_back();
    flush();
    repeat (5) pushByte(8'($urandom));
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
    checks++; if (buffer_occupancy !== 7'd5) begin fails++; $display("[TB] FAIL b2b_occ: got %0d expected 5", buffer_occupancy); end
    applyStimulus(1'b1, 32'h12345678, 2'd1, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
    checks++; if (buffer_occupancy !== 7'd5) begin fails++; $display("[TB] FAIL b2b_ahb_occ: got %0d expected 5", buffer_occupancy); end
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
    checks++; if ({buffer_occupancy, overflow, underflow} !== {7'd0, 2'b00}) begin fails++; $display("[TB] FAIL clear_occ: got occ %0d flags %b expected occ 0 flags 00", buffer_occupancy, {overflow, underflow}); end
  endtask

  task automatic test_async_reset();
    flush();
    repeat (3) pushByte(8'($urandom_range(1, 255)));
    #3;
    n_rst = 1'b0;
    #1;
    checks++; if ({buffer_occupancy, tx_packet_data} !== {7'd0, 8'h00}) begin fails++; $display("[TB] FAIL async_reset: got occ %0d tx %h expected occ 0 tx 00", buffer_occupancy, tx_packet_data); end
    @(negedge clk);
    n_rst = 1'b1;
    mq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int mode;
    for (int i = 0; i < 400; i++) begin
      mode = (i / 50) % 2;
      applyStimulus(($urandom_range(0, 9) < (mode ? 7 : 3)) ? 1'b1 : 1'b0, $urandom, 2'($urandom),
                    ($urandom_range(0, 9) < (mode ? 2 : 4)) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 9) < (mode ? 2 : 5)) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 9) < (mode ? 6 : 3)) ? 1'b1 : 1'b0,
                    8'($urandom), ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
      checks++; if (sampledRxData !== mdlRxData) begin fails++; $display("[TB] FAIL rand_rxdata cycle %0d: got %h expected %h", i, sampledRxData, mdlRxData); end
      checks++; if (buffer_occupancy !== 7'(mq.size())) begin fails++; $display("[TB] FAIL rand_occ cycle %0d: got %0d expected %0d", i, buffer_occupancy, mq.size()); end
      checks++; if ({overflow, underflow} !== {mdlOvf, mdlUnf}) begin fails++; $display("[TB] FAIL rand_flags cycle %0d: got %b expected %b", i, {overflow, underflow}, {mdlOvf, mdlUnf}); end
      if (mq.size() > 0) begin
        checks++; if (tx_packet_data !== mq[0]) begin fails++; $display("[TB] FAIL rand_head cycle %0d: got %h expected %h", i, tx_packet_data, mq[0]); end
      end
    end
  endtask

  // Scenario sequence followed by the one-line summary.
  initial begin
    test_reset();
    test_word_write();
    test_overflow();
    test_underflow();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
